// File: rtl/rv_pkg.sv
// Shared definitions for the register-file writeback path: register addressing
// and the arbiter grant encoding.
package rv_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  // x0 is hardwired to zero: never written, never tracked.
  function automatic logic is_zero_reg(logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: issue increments, register-file commit
// decrements, decode queries busy status combinationally.
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned PEND_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_valid_i,
  input  logic [REG_ADDR_W-1:0] inc_rd_i,
  output logic                  inc_sat_o,
  input  logic                  dec_valid_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  input  logic [REG_ADDR_W-1:0] q1_addr_i,
  input  logic [REG_ADDR_W-1:0] q2_addr_i,
  output logic                  q1_busy_o,
  output logic                  q2_busy_o,
  output logic                  sb_err_o
);

  logic [PEND_W-1:0] cnt_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_d [NUM_REGS];
  logic              err_q, err_d;
  logic              inc_fire;

  // x0 can never saturate, so issue to x0 is always accepted and ignored.
  assign inc_sat_o = !is_zero_reg(inc_rd_i) && (&cnt_q[inc_rd_i]);
  assign inc_fire  = inc_valid_i && !inc_sat_o && !is_zero_reg(inc_rd_i);

  assign q1_busy_o = !is_zero_reg(q1_addr_i) && (cnt_q[q1_addr_i] != '0);
  assign q2_busy_o = !is_zero_reg(q2_addr_i) && (cnt_q[q2_addr_i] != '0);
  assign sb_err_o  = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (inc_fire && (inc_rd_i == REG_ADDR_W'(i))) begin
        if (!(dec_valid_i && (dec_rd_i == REG_ADDR_W'(i)))) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (dec_valid_i && (dec_rd_i == REG_ADDR_W'(i)) && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    // Retiring a write nobody issued means the pipeline lost track of a destination.
    if (dec_valid_i && (cnt_q[dec_rd_i] == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// load pipes, with a registered write port and a pending-write scoreboard.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned PEND_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [WORD_SIZE-1:0]  alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [WORD_SIZE-1:0]  mem_data,
  output logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] rf_A3,
  output logic [WORD_SIZE-1:0]  rf_write_data,
  output logic                  rf_write_enable,
  output logic                  sb_err
);

  grant_e                last_grant_q, last_grant_d;
  logic [REG_ADDR_W-1:0] a3_q, a3_d;
  logic [WORD_SIZE-1:0]  wd_q, wd_d;
  logic                  we_q, we_d;
  logic                  alu_gnt, mem_gnt;
  logic                  issue_sat;

  always_comb begin
    // On a tie the source that lost last time wins.
    alu_gnt      = alu_valid && (!mem_valid || (last_grant_q == GRANT_MEM));
    mem_gnt      = mem_valid && !alu_gnt;
    last_grant_d = last_grant_q;
    a3_d         = a3_q;
    wd_d         = wd_q;
    we_d         = 1'b0;
    if (alu_gnt) begin
      last_grant_d = GRANT_ALU;
      a3_d         = alu_rd;
      wd_d         = alu_data;
      we_d         = !is_zero_reg(alu_rd);
    end else if (mem_gnt) begin
      last_grant_d = GRANT_MEM;
      a3_d         = mem_rd;
      wd_d         = mem_data;
      we_d         = !is_zero_reg(mem_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_MEM;
      a3_q         <= '0;
      wd_q         <= '0;
      we_q         <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      a3_q         <= a3_d;
      wd_q         <= wd_d;
      we_q         <= we_d;
    end
  end

  assign alu_ready       = alu_gnt;
  assign mem_ready       = mem_gnt;
  assign rf_A3           = a3_q;
  assign rf_write_data   = wd_q;
  assign rf_write_enable = we_q;
  assign issue_ready     = !issue_sat;

  // Retire on the same edge the register file commits, so busy never
  // clears before the new value is readable.
  reg_scoreboard #(
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_valid_i (issue_valid),
    .inc_rd_i    (issue_rd),
    .inc_sat_o   (issue_sat),
    .dec_valid_i (we_q),
    .dec_rd_i    (a3_q),
    .q1_addr_i   (rs1_addr),
    .q2_addr_i   (rs2_addr),
    .q1_busy_o   (rs1_busy),
    .q2_busy_o   (rs2_busy),
    .sb_err_o    (sb_err)
  );

endmodule
